// File: rtl/series_pkg.sv
`default_nettype none
// ============================================================================
// Module   : series_pkg
// Purpose  : Shared types and constants for the series reduction path
//            (series_collector, series_reducer).
// Contents : bank_state_t - per-bank state {EMPTY, FILLING, FULL}
//            cnt_w()      - width needed to hold a word count 0..n
//            c_DEFAULT_*  - default frame geometry
// Revision : 1.0 - initial release
// ============================================================================
package series_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int c_DEFAULT_WIDTH = 32;
    localparam int c_DEFAULT_N     = 32;

    // Count width: a frame holds 0..n words, so n+1 distinct values.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/series_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : series_collector_if
// Purpose  : Bundles the input word stream and the output frame handshake of
//            the series collector.
// Signals  : in_data/in_valid/in_last/in_ready  - word stream (valid/ready)
//            numbers/frame_sum/frame_count      - frame payload
//            frame_valid/frame_ready            - frame handshake
// Modports : master - stream source and frame sink (test/upstream side)
//            slave  - the collector itself
// Revision : 1.0 - initial release
// ============================================================================
interface series_collector_if #(
    parameter int N     = series_pkg::c_DEFAULT_N,
    parameter int WIDTH = series_pkg::c_DEFAULT_WIDTH
);
    import series_pkg::*;

    localparam int c_CNT_W = cnt_w(N);

    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_ready;
    logic [N-1:0][WIDTH-1:0]   numbers;
    logic [WIDTH-1:0]          frame_sum;
    logic [c_CNT_W-1:0]        frame_count;
    logic                      frame_valid;
    logic                      frame_ready;

    modport master (
        output in_data, in_valid, in_last, frame_ready,
        input  in_ready, numbers, frame_sum, frame_count, frame_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, frame_ready,
        output in_ready, numbers, frame_sum, frame_count, frame_valid
    );

endinterface
`default_nettype wire

// File: rtl/series_bank.sv
`default_nettype none
// ============================================================================
// Module   : series_bank
// Purpose  : One frame buffer: N word slots, word count, running sum
//            (mod 2^WIDTH) and an EMPTY/FILLING/FULL state.
// Ports    : clk, reset      - clock, async active-low reset
//            i_wr_en         - accept i_wr_data into slot o_count
//            i_wr_data       - word to store
//            i_wr_last       - this word closes the frame early
//            i_clear         - frame popped: clear storage, go EMPTY
//            o_slots         - stored words, slot 0 first received
//            o_count/o_sum   - words held / their sum
//            o_state         - bank state
//            o_closing       - the current write closes this bank
// Revision : 1.0 - initial release
// ============================================================================
module series_bank
    import series_pkg::*;
#(
    parameter int N     = c_DEFAULT_N,
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     i_wr_en,
    input  wire logic [WIDTH-1:0]         i_wr_data,
    input  wire logic                     i_wr_last,
    input  wire logic                     i_clear,
    output logic      [N-1:0][WIDTH-1:0]  o_slots,
    output logic      [cnt_w(N)-1:0]      o_count,
    output logic      [WIDTH-1:0]         o_sum,
    output bank_state_t                   o_state,
    output logic                          o_closing
);

    localparam int c_CNT_W = cnt_w(N);

    bank_state_t                r_state;
    bank_state_t                w_state_nxt;
    logic [N-1:0][WIDTH-1:0]    r_slots;
    logic [c_CNT_W-1:0]         r_count;
    logic [WIDTH-1:0]           r_sum;

    // The N-th word closes the bank whether or not in_last is also set.
    assign o_closing = i_wr_en && (i_wr_last || (r_count == c_CNT_W'(N - 1)));

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = EMPTY;
        end else if (i_wr_en) begin
            w_state_nxt = o_closing ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clearing on pop keeps unused slots of short frames at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slots <= '0;
            r_count <= '0;
            r_sum   <= '0;
        end else if (i_clear) begin
            r_slots <= '0;
            r_count <= '0;
            r_sum   <= '0;
        end else if (i_wr_en) begin
            for (int i = 0; i < N; i++) begin
                if (r_count == c_CNT_W'(i)) begin
                    r_slots[i] <= i_wr_data;
                end
            end
            r_count <= r_count + c_CNT_W'(1);
            r_sum   <= r_sum + i_wr_data;
        end
    end

    assign o_slots = r_slots;
    assign o_count = r_count;
    assign o_sum   = r_sum;
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/series_collector.sv
`default_nettype none
// ============================================================================
// Module   : series_collector
// Purpose  : Packs a valid/ready stream of WIDTH-bit words into frames of up
//            to N words using two ping-pong banks, presenting each frame with
//            its word count and sum (mod 2^WIDTH).
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-low reset
//            bus    - series_collector_if.slave (stream in, frame out)
// Revision : 1.0 - initial release
// ============================================================================
module series_collector
    import series_pkg::*;
#(
    parameter int N     = c_DEFAULT_N,
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           reset,
    series_collector_if.slave   bus
);

    localparam int c_CNT_W = cnt_w(N);

    logic                       r_wr_bank;
    logic                       r_rd_bank;

    bank_state_t                w_state   [2];
    logic [N-1:0][WIDTH-1:0]    w_slots   [2];
    logic [c_CNT_W-1:0]         w_count   [2];
    logic [WIDTH-1:0]           w_sum     [2];
    logic                       w_closing [2];
    logic                       w_wr_en   [2];
    logic                       w_clear   [2];

    logic                       w_in_ready;
    logic                       w_frame_valid;
    logic                       w_accept;
    logic                       w_pop;

    // Both flags come from registered bank state only, so neither in_valid
    // nor frame_ready has a combinational path to an output.
    assign w_in_ready    = (w_state[r_wr_bank] != FULL);
    assign w_frame_valid = (w_state[r_rd_bank] == FULL);
    assign w_accept      = bus.in_valid && w_in_ready;
    assign w_pop         = w_frame_valid && bus.frame_ready;

    generate
        for (genvar g = 0; g < 2; g++) begin : g_bank
            assign w_wr_en[g] = w_accept && (r_wr_bank == 1'(g));
            assign w_clear[g] = w_pop    && (r_rd_bank == 1'(g));

            series_bank #(
                .N     (N),
                .WIDTH (WIDTH)
            ) u_bank (
                .clk       (clk),
                .reset     (reset),
                .i_wr_en   (w_wr_en[g]),
                .i_wr_data (bus.in_data),
                .i_wr_last (bus.in_last),
                .i_clear   (w_clear[g]),
                .o_slots   (w_slots[g]),
                .o_count   (w_count[g]),
                .o_sum     (w_sum[g]),
                .o_state   (w_state[g]),
                .o_closing (w_closing[g])
            );
        end
    endgenerate

    // Pointers move independently; a close and a pop in the same cycle both
    // take effect, so the freshly closed bank is presented next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_closing[r_wr_bank]) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_pop) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.frame_valid = w_frame_valid;
    assign bus.numbers     = w_slots[r_rd_bank];
    assign bus.frame_sum   = w_sum[r_rd_bank];
    assign bus.frame_count = w_count[r_rd_bank];

endmodule
`default_nettype wire

// File: tb/tb_series_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_series_collector
// Purpose  : Self-checking bench for series_collector (N=4, WIDTH=8).
//            A reference model builds expected frames as words are accepted;
//            a monitor pops them when the DUT hands a frame downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_series_collector;

    localparam int c_N = 4;
    localparam int c_W = 8;

    typedef struct {
        logic [c_N-1:0][c_W-1:0] nums;
        logic [c_W-1:0]          sum;
        logic [2:0]              cnt;
    } frame_t;

    logic clk;
    logic reset;

    series_collector_if #(.N(c_N), .WIDTH(c_W)) bus ();

    series_collector #(.N(c_N), .WIDTH(c_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp   = 0;
    int n_err   = 0;
    int n_pops  = 0;
    int n_stall = 0;

    frame_t exp_q [$];
    logic [c_W-1:0] pop_sums [$];

    logic [c_N-1:0][c_W-1:0] m_nums;
    logic [c_W-1:0]          m_sum;
    int                      m_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_nums = '0;
        m_sum  = '0;
        m_n    = 0;
    endtask

    task automatic model_accept(input logic [c_W-1:0] d, input logic l);
        frame_t f;
        m_nums[m_n] = d;
        m_n++;
        m_sum = m_sum + d;
        if (m_n == c_N || l) begin
            f.nums = m_nums;
            f.sum  = m_sum;
            f.cnt  = 3'(m_n);
            exp_q.push_back(f);
            model_clear();
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [c_W-1:0] d, input logic l);
        int guard = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            n_stall++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            chk("send_timeout", 64'(guard), 64'(0));
        end else begin
            @(posedge clk);
            model_accept(d, l);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Frame monitor: a pop happens at the next rising edge.
    always @(negedge clk) begin
        frame_t f;
        #1;
        if (bus.frame_valid && bus.frame_ready) begin
            n_pops++;
            pop_sums.push_back(bus.frame_sum);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_frame", 64'(bus.frame_sum), 64'hDEAD);
            end else begin
                f = exp_q.pop_front();
                chk("sb_numbers", 64'(bus.numbers), 64'(f.nums));
                chk("sb_sum", 64'(bus.frame_sum), 64'(f.sum));
                chk("sb_count", 64'(bus.frame_count), 64'(f.cnt));
            end
        end
    end

    initial begin
        int base;
        int stall0;
        model_clear();
        reset           = 1'b0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b0;
        idle(3);

        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_frame_valid", 64'(bus.frame_valid), 64'(0));
        chk("rst_numbers", 64'(bus.numbers), 64'(0));
        chk("rst_sum", 64'(bus.frame_sum), 64'(0));
        chk("rst_count", 64'(bus.frame_count), 64'(0));
        reset = 1'b1;
        idle(2);

        // Full frame of four words
        bus.frame_ready = 1'b1;
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        chk("t1_valid_before_close", 64'(bus.frame_valid), 64'(0));
        send(8'd4, 1'b0);
        chk("t1_valid", 64'(bus.frame_valid), 64'(1));
        chk("t1_numbers", 64'(bus.numbers), 64'h04030201);
        chk("t1_count", 64'(bus.frame_count), 64'(4));
        chk("t1_sum", 64'(bus.frame_sum), 64'(10));
        idle(2);
        chk("t1_valid_after_pop", 64'(bus.frame_valid), 64'(0));

        // Early close with sum wrap
        send(8'hFF, 1'b0);
        send(8'h02, 1'b1);
        chk("t2_valid", 64'(bus.frame_valid), 64'(1));
        chk("t2_count", 64'(bus.frame_count), 64'(2));
        chk("t2_sum", 64'(bus.frame_sum), 64'h01);
        chk("t2_numbers", 64'(bus.numbers), 64'h000002FF);
        idle(2);

        // Backpressure: both banks fill, ninth word stalls
        bus.frame_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        chk("t3_in_ready_full", 64'(bus.in_ready), 64'(0));
        chk("t3_valid", 64'(bus.frame_valid), 64'(1));
        chk("t3_sum_first", 64'(bus.frame_sum), 64'(10));
        bus.in_data  = 8'd9;
        bus.in_valid = 1'b1;
        idle(3);
        chk("t3_stall_ready", 64'(bus.in_ready), 64'(0));
        chk("t3_held_sum", 64'(bus.frame_sum), 64'(10));
        chk("t3_held_numbers", 64'(bus.numbers), 64'h04030201);
        bus.in_valid = 1'b0;
        bus.frame_ready = 1'b1;
        @(negedge clk);
        bus.frame_ready = 1'b0;
        chk("t3_in_ready_after_pop", 64'(bus.in_ready), 64'(1));
        chk("t3_valid_second", 64'(bus.frame_valid), 64'(1));
        chk("t3_sum_second", 64'(bus.frame_sum), 64'(26));
        bus.frame_ready = 1'b1;
        idle(2);
        chk("t3_drained", 64'(bus.frame_valid), 64'(0));

        // Continuous stream, pops coincide with closes
        base   = pop_sums.size();
        stall0 = n_stall;
        for (int i = 1; i <= 12; i++) send(8'(i), 1'b0);
        idle(3);
        chk("t4_no_stall", 64'(n_stall - stall0), 64'(0));
        chk("t4_frames", 64'(pop_sums.size() - base), 64'(3));
        if (pop_sums.size() >= base + 3) begin
            chk("t4_sum0", 64'(pop_sums[base]), 64'(10));
            chk("t4_sum1", 64'(pop_sums[base+1]), 64'(26));
            chk("t4_sum2", 64'(pop_sums[base+2]), 64'(42));
        end

        // Reset mid-frame discards the partial frame
        send(8'd5, 1'b0);
        send(8'd6, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        model_clear();
        chk("t5_in_ready", 64'(bus.in_ready), 64'(1));
        chk("t5_valid", 64'(bus.frame_valid), 64'(0));
        chk("t5_numbers", 64'(bus.numbers), 64'(0));
        chk("t5_sum", 64'(bus.frame_sum), 64'(0));
        chk("t5_count", 64'(bus.frame_count), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(8'd7, 1'b0);
        chk("t5_sum_restart", 64'(bus.frame_sum), 64'(28));
        chk("t5_count_restart", 64'(bus.frame_count), 64'(4));
        idle(2);

        // Single-word frame
        send(8'h55, 1'b1);
        chk("t6_count", 64'(bus.frame_count), 64'(1));
        chk("t6_numbers", 64'(bus.numbers), 64'h00000055);
        chk("t6_sum", 64'(bus.frame_sum), 64'h55);
        idle(3);

        chk("sb_empty", 64'(exp_q.size()), 64'(0));
        chk("total_pops", 64'(n_pops), 64'(9));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/series_collector.md
# series_collector

Serial-to-parallel front end for the series reduction path. It accepts a valid/ready stream of WIDTH-bit words and packs up to N of them into one frame. Each frame is presented as the `numbers` vector that the series reducer consumes, together with a word count and a reference sum (modulo 2^WIDTH). Two banks are used ping-pong, so the stream keeps flowing while the downstream holds a completed frame.

## Interface
- N, 32, words per frame; N ≥ 2, power of two not required
- WIDTH, 32, bits per word and per sum
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- in_data  in  WIDTH  stream word
- in_valid  in  1  in_data valid
- in_last  in  1  word closes the frame early; qualified by in_valid
- in_ready  out  1  collector can accept a word this cycle
- numbers  out  [N-1:0][WIDTH-1:0]  frame words; slot 0 = first word received
- frame_sum  out  WIDTH  sum of the frame's words, mod 2^WIDTH
- frame_count  out  $clog2(N+1)  number of valid words, 1..N
- frame_valid  out  1  frame outputs valid
- frame_ready  in  1  downstream takes the frame

## Operation
- Banks: two, each with its own state.
  - EMPTY→FILLING on the first accepted word.
  - FILLING→FULL on accept of the N-th word, or on any accepted word with in_last=1.
  - FULL→EMPTY on frame pop.
- Write pointer `wr_bank` selects the bank being filled. It toggles when that bank closes.
- Read pointer `rd_bank` selects the bank being presented. It toggles on pop.
- Word acceptance: in_valid && in_ready.
  - The word is written to slot `count` of the wr_bank.
  - count increments.
  - sum ← sum + in_data, truncated to WIDTH bits (wrap-around, no carry out).
- in_ready = (state[wr_bank] != FULL). This is combinational from registered state only, with no path from in_valid.
- frame_valid = (state[rd_bank] == FULL).
- Pop = frame_valid && frame_ready. On pop, the bank's count, sum and all slots clear to 0. Slots at index ≥ frame_count therefore always read 0 (zero fill for short frames).
- in_last on the N-th word closes the frame once; the flag is redundant, with no extra effect.
- Simultaneous pop of rd_bank and close of wr_bank in the same cycle:
  - Both take effect.
  - frame_valid stays 1 in the next cycle and presents the other bank.
- Pop while the wr_bank is FULL (both banks full):
  - in_ready rises in the cycle after the pop edge.
  - The freed bank is now wr_bank.
- frame_ready while frame_valid=0 is ignored.
- Reset (any time, including mid-frame):
  - Both banks go EMPTY, all slots, counts and sums go to 0, and both pointers go to bank 0.
  - Any partial frame is discarded.
- Output reset values:
  - in_ready=1
  - frame_valid=0
  - numbers=0
  - frame_sum=0
  - frame_count=0

## Timing
- Latency: the closing word is accepted at edge t and frame_valid=1 in the cycle after t. numbers, frame_sum and frame_count are stable from that cycle until the pop edge.
- Sum: the last word's contribution is included in frame_sum in the same cycle frame_valid rises. There is no extra pipeline stage.
- Throughput: with frame_ready held 1, one word per cycle sustained. in_ready never drops.
- Backpressure: frame_ready=0 holds the outputs unchanged. After one further frame fills, in_ready=0 until a pop.
- No combinational path from in_valid or in_data to any output. frame_ready affects only the registered state.

## Structure
- Shared package `series_pkg`:
  - bank state enum {EMPTY, FILLING, FULL}
  - CNT_W = $clog2(N+1) count-width helper
  - default WIDTH constant, shared with series_reducer
- Sub-module `series_bank`, instantiated twice: N-slot storage, count, running sum and state, with write, close and clear controls.
- Top level holds wr_bank/rd_bank, the in_ready/frame_valid logic and the output mux.

## Test plan
- N=4, WIDTH=8; stream 1,2,3,4 with no in_last, frame_ready=1 → frame_valid one cycle after word 4; numbers={4,3,2,1} (slot 3..0); frame_count=4; frame_sum=10.
- Stream 0xFF, 0x02 with in_last on 0x02 → frame_count=2; frame_sum=0x01 (wrap); slots 2,3 = 0.
- frame_ready=0; stream 8 words → frames {1..4} and {5..8} held; in_ready=0 after the 8th word; word 9 stalls. Pulse frame_ready → frame_sum 10 popped; in_ready=1 next cycle; then frame_sum=26 presented.
- Continuous stream of 12 words with frame_ready=1 → in_ready constantly 1; three frames with sums 10, 26, 42; pop and close coincide without a dropped frame.
- Assert reset after 2 words of a frame → in_ready=1, frame_valid=0, all outputs 0. Restart with 7,7,7,7 → frame_sum=28, frame_count=4.
- frame_ready=1 with no frame pending; in_last on the first word 0x55 → frame_count=1; numbers slot 0=0x55, others 0; frame_sum=0x55.
